mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter that shares the single `mem_control` port (256-bit line, 18-bit line address, `wren`) among `N_REQ` requesters, such as vector lanes, a loader and a debug port. It accepts one request at a time and drives exactly one memory cycle per transaction. Read data returns to the winner with a one-hot response strobe. It sits between the requesters and `mem_control`; `mem_control` ports connect directly to the `mem_*` ports.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `RD_LAT`, 2: read latency of `mem_control`, in cycles from the sampling edge to valid `q` (≥1).
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: request pending, per requester.
- `req_wren` in N_REQ: 1 = write, 0 = read.
- `req_addr` in [N_REQ-1:0][17:0]: line address.
- `req_data` in [N_REQ-1:0][15:0][15:0]: write line.
- `req_ready` out N_REQ: one-hot accept; transfer occurs on the edge where `req_valid[i] & req_ready[i]`.
- `rsp_valid` out N_REQ: one-hot, one-cycle completion strobe (reads and writes).
- `rsp_q` out [15:0][15:0]: read line for the current `rsp_valid` owner.
- `mem_address` out 18, `mem_data` out [15:0][15:0], `mem_wren` out 1: to `mem_control`.
- `mem_q` in [15:0][15:0]: from `mem_control`.
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states:
  - IDLE → ISSUE on accept.
  - ISSUE → WAIT (read) or RESP (write).
  - WAIT → RESP after RD_LAT cycles.
  - RESP → IDLE.
- IDLE:
  - `req_ready` is combinational and one-hot: the first `req_valid` set, searching from `ptr` upward with wrap.
  - Zero when no request is pending, and zero in all other states.
  - On accept, the FSM captures `wren`, `addr`, `data` and the winner index, and sets `ptr` to (winner+1) mod N_REQ.
- Requester rules:
  - A requester holds `req_valid` and payload stable until accepted.
  - Dropping `req_valid` before acceptance is legal and has no effect.
- ISSUE:
  - `mem_address` and `mem_data` are driven from the captured registers.
  - `mem_wren` = captured wren, for exactly this one cycle. `mem_wren` = 0 in every other state.
  - `mem_address` and `mem_data` hold their last value outside ISSUE.
- WAIT: a down-counter loaded with RD_LAT-1. When it reaches 0, `mem_q` is registered into `rsp_q`.
- RESP:
  - `rsp_valid[winner]` = 1 for one cycle.
  - `rsp_q` changes only on reads; it holds until the next read completes.
- Write responses carry no data.

## Timing
- Reset value of every output and register is 0: `req_ready`, `rsp_valid`, `rsp_q`, `mem_*`, `busy`, `ptr`. The FSM resets to IDLE.
- Reset mid-transaction aborts the transaction: no `rsp_valid` is produced, and `mem_wren` drops asynchronously with reset.
- Let accept edge = end of cycle c0.
  - Write: ISSUE in c1 (memory samples at the end of c1); RESP in c2; IDLE in c3.
  - Read: ISSUE in c1; WAIT in c2..c(1+RD_LAT) (`mem_q` valid in c(1+RD_LAT)); RESP in c(2+RD_LAT).
- Back-to-back throughput: one write per 3 cycles, one read per RD_LAT+3 cycles. No accept occurs during RESP.
- Fairness: with all N_REQ valid continuously, grants are strictly cyclic, so each requester waits at most N_REQ-1 transactions.
- Simultaneous events: a new `req_valid` arriving during a transaction is only considered in the next IDLE cycle. The winner is decided by `ptr` at that cycle.
- Wrap-around: `ptr` = N_REQ-1 followed by a grant to N_REQ-1 sets `ptr` = 0.

## Test plan
- Reset: hold `rst`=0 with all `req_valid`=1. Required: `req_ready`=0, `mem_wren`=0, `busy`=0. After release, the first grant goes to requester 0.
- Single write then read: requester 1 writes data=1 at addr 0x00005, then reads 0x00005. Required:
  - `mem_wren`=1 for exactly one cycle, in c1.
  - `rsp_valid`=4'b0010 in c2.
  - The read returns `rsp_q`=1 with `rsp_valid`=4'b0010 in c(2+RD_LAT) = c4.
- Round-robin: all 4 requesters read continuously, with distinct addresses. Required: grant order 0,1,2,3,0,1; accepts spaced exactly RD_LAT+3 = 5 cycles apart.
- Withdrawal: requester 2 raises `req_valid` during requester 0's transaction, then drops it before IDLE. Required: no grant to requester 2; `busy` falls.
- Mid-read reset: assert `rst`=0 in the WAIT cycle. Required: no `rsp_valid`, `rsp_q`=0, FSM in IDLE after release.
- Pointer wrap: grant requester 3 first, then make requesters 0 and 3 valid together. Required: next grant is requester 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one mem_control port among N_REQ requesters.
// One request is accepted at a time and each transaction drives exactly one memory cycle.
module mem_arbiter #(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0]              req_wren,
  input  logic [N_REQ-1:0][17:0]        req_addr,
  input  logic [N_REQ-1:0][15:0][15:0]  req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [15:0][15:0]             rsp_q,
  output logic [17:0]                   mem_address,
  output logic [15:0][15:0]             mem_data,
  output logic                          mem_wren,
  input  logic [15:0][15:0]             mem_q,
  output logic                          busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(RD_LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [PW-1:0]         ptr_r;
  logic [PW-1:0]         win_r;
  logic                  wren_r;
  logic [CW-1:0]         cnt_r;
  logic [N_REQ-1:0]      rsp_valid_r;
  logic [15:0][15:0]     rsp_q_r;
  logic [17:0]           mem_address_r;
  logic [15:0][15:0]     mem_data_r;
  logic                  mem_wren_r;
  logic                  busy_r;

  logic [N_REQ-1:0]      grant_s;
  logic [PW-1:0]         win_s;
  logic                  accept_s;
  logic [PW:0]           pos_s;
  logic [PW-1:0]         idx_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Grant search: first pending requester at or above ptr, wrapping; only while idle and out of reset.
  always_comb begin
    grant_s  = '0;
    win_s    = '0;
    accept_s = 1'b0;
    pos_s    = '0;
    idx_s    = '0;
    if ((state_r == IDLE) && rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        pos_s = {1'b0, ptr_r} + (PW+1)'(k);
        if (pos_s >= (PW+1)'(N_REQ)) begin
          pos_s = pos_s - (PW+1)'(N_REQ);
        end else begin
          pos_s = pos_s;
        end
        idx_s = pos_s[PW-1:0];
        if (!accept_s && req_valid[idx_s]) begin
          accept_s       = 1'b1;
          grant_s[idx_s] = 1'b1;
          win_s          = idx_s;
        end else begin
          accept_s = accept_s;
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = ISSUE;
        else          state_nx_s = IDLE;
      end
      ISSUE: begin
        if (wren_r) state_nx_s = RESP;
        else        state_nx_s = WAIT;
      end
      WAIT: begin
        if (cnt_r == '0) state_nx_s = RESP;
        else             state_nx_s = WAIT;
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Capture of the winning request, memory drive, read-latency counter and response strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r         <= '0;
      win_r         <= '0;
      wren_r        <= 1'b0;
      cnt_r         <= '0;
      rsp_valid_r   <= '0;
      rsp_q_r       <= '0;
      mem_address_r <= '0;
      mem_data_r    <= '0;
      mem_wren_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      mem_wren_r  <= 1'b0;
      rsp_valid_r <= '0;
      busy_r      <= (state_nx_s != IDLE);
      if (accept_s) begin
        win_r         <= win_s;
        wren_r        <= req_wren[win_s];
        mem_address_r <= req_addr[win_s];
        mem_data_r    <= req_data[win_s];
        mem_wren_r    <= req_wren[win_s];
        if (win_s == PW'(N_REQ - 1)) ptr_r <= '0;
        else                         ptr_r <= win_s + PW'(1);
      end
      if (state_r == ISSUE) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CW'(1);
      end
      // mem_q is valid in the last WAIT cycle; rsp_q only ever moves on reads.
      if ((state_r == WAIT) && (cnt_r == '0)) begin
        rsp_q_r <= mem_q;
      end
      if (state_nx_s == RESP) begin
        rsp_valid_r <= onehot(win_r);
      end
    end
  end

  assign req_ready   = grant_s;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_q       = rsp_q_r;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;
  assign mem_wren    = mem_wren_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected grants/responses,
// a monitor pops and compares whenever the arbiter grants or responds.
module tb_mem_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_wren;
  logic [N-1:0][17:0]     req_addr;
  logic [N-1:0][15:0][15:0] req_data;
  logic [N-1:0]           req_ready;
  logic [N-1:0]           rsp_valid;
  logic [15:0][15:0]      rsp_q;
  logic [17:0]            mem_address;
  logic [15:0][15:0]      mem_data;
  logic                   mem_wren;
  logic [15:0][15:0]      mem_q;
  logic                   busy;

  typedef struct {
    logic [N-1:0] v;
    logic [255:0] q;
  } rsp_t;

  rsp_t rsp_exp[$];
  int   grant_exp[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.N_REQ(N), .RD_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wren(req_wren), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_q(rsp_q),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_q(mem_q), .busy(busy)
  );

  // Preloaded line contents for never-written addresses.
  function automatic logic [255:0] pat(input int a);
    return {16{16'hA000 + 16'(a)}};
  endfunction

  // Memory stand-in with a fixed read latency of LAT cycles.
  logic [255:0] mem [64];
  bit   [63:0]  wr_flag;
  logic [255:0] pipe [LAT];

  always @(posedge clk) begin
    if (mem_wren) begin
      mem[mem_address[5:0]]     <= mem_data;
      wr_flag[mem_address[5:0]] <= 1'b1;
    end
    pipe[0] <= wr_flag[mem_address[5:0]] ? mem[mem_address[5:0]] : pat(int'(mem_address[5:0]));
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign mem_q = pipe[LAT-1];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: compare every grant and response against the scoreboard queues.
  rsp_t e;
  int   g;
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (rsp_exp.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: got rsp_valid %0h expected none", rsp_valid);
      end else begin
        e = rsp_exp.pop_front();
        check("rsp_valid", 256'(rsp_valid), 256'(e.v));
        check("rsp_q", rsp_q, e.q);
      end
    end
    if ((req_valid & req_ready) !== '0) begin
      if (grant_exp.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_grant: got req_ready %0h expected none", req_ready);
      end else begin
        g = grant_exp.pop_front();
        check("grant", 256'(req_ready), 256'(1) << g);
      end
    end
  end

  task automatic set_req(input int i, input logic w, input int a, input logic [255:0] d);
    req_wren[i]  = w;
    req_addr[i]  = 18'(a);
    req_data[i]  = d;
    req_valid[i] = 1'b1;
  endtask

  // Returns just after the accepting edge (time = posedge + 1, cycle c1).
  task automatic wait_accept(output int at);
    bit got;
    got = 1'b0;
    at  = -1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) begin
        got = 1'b1;
        @(posedge clk);
        #1;
        at = cyc;
      end
    end
    if (!got) begin
      n_chk++;
      $display("FAIL accept_timeout: got no accept in 50 cycles, expected one");
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      $display("FAIL idle_timeout: got busy=1 for 50 cycles, expected 0");
    end
  endtask

  int at, prev;
  logic [255:0] last_q;

  initial begin
    req_valid = '0; req_wren = '0; req_addr = '0; req_data = '0;
    rst = 1'b0; last_q = '0;

    // Reset with every requester pending.
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 'h20 + i, '0);
    repeat (3) @(negedge clk);
    check("rst_req_ready", 256'(req_ready), 256'(0));
    check("rst_mem_wren", 256'(mem_wren), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst_rsp_q", rsp_q, 256'(0));
    grant_exp.push_back(0);
    rsp_exp.push_back('{v: 4'b0001, q: pat('h20)});
    last_q = pat('h20);
    @(posedge clk); #1 rst = 1'b1;
    wait_accept(at);
    req_valid = '0;
    wait_idle();

    // Requester 1 writes 1 to 0x00005 then reads it back.
    @(posedge clk); #1;
    grant_exp.push_back(1);
    rsp_exp.push_back('{v: 4'b0010, q: last_q});
    set_req(1, 1'b1, 'h5, 256'd1);
    wait_accept(at);
    req_valid = '0;
    @(negedge clk);
    check("wr_c1_mem_wren", 256'(mem_wren), 256'(1));
    check("wr_c1_mem_address", 256'(mem_address), 256'(5));
    check("wr_c1_mem_data", mem_data, 256'(1));
    @(negedge clk);
    check("wr_c2_mem_wren", 256'(mem_wren), 256'(0));
    check("wr_c2_rsp_valid", 256'(rsp_valid), 256'(4'b0010));
    @(negedge clk);
    check("wr_c3_busy", 256'(busy), 256'(0));

    @(posedge clk); #1;
    grant_exp.push_back(1);
    rsp_exp.push_back('{v: 4'b0010, q: 256'd1});
    last_q = 256'd1;
    set_req(1, 1'b0, 'h5, '0);
    wait_accept(at);
    req_valid = '0;
    @(negedge clk);
    check("rd_c1_mem_wren", 256'(mem_wren), 256'(0));
    @(negedge clk);
    check("rd_c2_busy", 256'(busy), 256'(1));
    @(negedge clk);
    check("rd_c3_rsp_valid", 256'(rsp_valid), 256'(0));
    @(negedge clk);
    check("rd_c4_rsp_valid", 256'(rsp_valid), 256'(4'b0010));
    check("rd_c4_rsp_q", rsp_q, 256'd1);
    @(negedge clk);
    check("rd_c5_busy", 256'(busy), 256'(0));

    // Pointer wrap: grant 3 alone, then 0 and 3 together must pick 0.
    @(posedge clk); #1;
    grant_exp.push_back(3);
    rsp_exp.push_back('{v: 4'b1000, q: pat('h23)});
    set_req(3, 1'b0, 'h23, '0);
    wait_accept(at);
    req_valid = '0;
    wait_idle();
    @(posedge clk); #1;
    grant_exp.push_back(0);
    rsp_exp.push_back('{v: 4'b0001, q: pat('h20)});
    grant_exp.push_back(3);
    rsp_exp.push_back('{v: 4'b1000, q: pat('h23)});
    set_req(0, 1'b0, 'h20, '0);
    set_req(3, 1'b0, 'h23, '0);
    wait_accept(at);
    req_valid[0] = 1'b0;
    wait_accept(at);
    req_valid = '0;
    wait_idle();

    // Round robin with all four reading continuously.
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      grant_exp.push_back(k % N);
      rsp_exp.push_back('{v: 4'(1 << (k % N)), q: pat('h20 + (k % N))});
    end
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 'h20 + i, '0);
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_accept(at);
      if (k > 0) check("accept_spacing", 256'(at - prev), 256'(LAT + 3));
      prev = at;
    end
    req_valid = '0;
    wait_idle();
    last_q = pat('h21);

    // Withdrawal: requester 2 appears and leaves during requester 0's read.
    @(posedge clk); #1;
    grant_exp.push_back(0);
    rsp_exp.push_back('{v: 4'b0001, q: pat('h20)});
    set_req(0, 1'b0, 'h20, '0);
    wait_accept(at);
    req_valid = '0;
    set_req(2, 1'b0, 'h22, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("wd_busy", 256'(busy), 256'(0));
    check("wd_req_ready", 256'(req_ready), 256'(0));

    // Reset asserted during the WAIT cycle of a read.
    @(posedge clk); #1;
    grant_exp.push_back(1);
    set_req(1, 1'b0, 'h21, '0);
    wait_accept(at);
    req_valid = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mr_rsp_valid", 256'(rsp_valid), 256'(0));
    check("mr_rsp_q", rsp_q, 256'(0));
    check("mr_busy", 256'(busy), 256'(0));
    check("mr_mem_wren", 256'(mem_wren), 256'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("mr_idle_busy", 256'(busy), 256'(0));
    check("mr_idle_rsp_valid", 256'(rsp_valid), 256'(0));
    @(posedge clk); #1;
    grant_exp.push_back(2);
    rsp_exp.push_back('{v: 4'b0100, q: pat('h22)});
    set_req(2, 1'b0, 'h22, '0);
    @(negedge clk);
    check("mr_idle_ready", 256'(req_ready), 256'(4'b0100));
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    repeat (2) @(negedge clk);

    check("grant_queue_empty", 256'(grant_exp.size()), 256'(0));
    check("rsp_queue_empty", 256'(rsp_exp.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier");
    $fatal(1);
  end

endmodule
